tag_fifo: RTL and testbench

- Upstream tag allocator for the register status table in the RISC-V superscalar dispatch path.
- Holds the free pool of 6-bit issue tags. Dispatch pops one tag per renamed destination and writes {1'b1, tag} into the status table.
- Tags return to the pool when their result is broadcast on the CDB (cdb_valid, cdb_tag).
- Circular FIFO, one pop and one push per cycle.

---
 rtl/riscv_sp_pkg.sv | 11 +
 rtl/tag_fifo.sv | 88 ++++++++
 tb/tb_tag_fifo.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_sp_pkg.sv
// Shared types for the superscalar dispatch path. The tag allocator,
// status table and CDB blocks all use these definitions.
package riscv_sp_pkg;

  localparam int unsigned TAG_W    = 6;
  localparam int unsigned NUM_TAGS = 64;

  typedef logic [TAG_W-1:0] tag_t;      // issue tag
  typedef logic [TAG_W:0]   tag_cnt_t;  // 0..NUM_TAGS inclusive

endpackage : riscv_sp_pkg

// File: rtl/tag_fifo.sv
// tag_fifo: free pool of issue tags, organised as a circular FIFO.
// Dispatch pops a tag for each renamed destination. A CDB broadcast
// pushes its tag back into the pool.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   tag_pop    - dispatch consumes tag_out this cycle
//   tag_out    - head tag (first-word fall-through)
//   tag_avail  - pool non-empty
//   cdb_valid  - CDB broadcast; return cdb_tag to the pool
//   cdb_tag    - tag being freed
//   tag_count  - free tags held, 0..NUM_TAGS
//   ovf_err    - sticky: push dropped while full with no pop
//   udf_err    - sticky: pop requested while empty
module tag_fifo
  import riscv_sp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tag_pop,
  output logic [TAG_W-1:0] tag_out,
  output logic             tag_avail,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  output logic [TAG_W:0]   tag_count,
  output logic             ovf_err,
  output logic             udf_err
);

  localparam int unsigned DEPTH = NUM_TAGS;

  tag_t     r_mem [DEPTH];
  tag_t     r_rd_ptr;
  tag_t     r_wr_ptr;
  tag_cnt_t r_count;
  logic     r_ovf;
  logic     r_udf;

  logic     w_avail;
  logic     w_full;
  logic     w_pop_ok;
  logic     w_push_ok;

  // Accept decisions. A push into a full pool is allowed only when a
  // pop frees a slot in the same cycle. A pop never bypasses a push
  // made to an empty pool.
  always_comb begin
    w_avail   = (r_count != tag_cnt_t'(0));
    w_full    = (r_count == tag_cnt_t'(DEPTH));
    w_pop_ok  = tag_pop && w_avail;
    w_push_ok = cdb_valid && (!w_full || w_pop_ok);
  end

  // Storage: reset reloads the pool with tags 0..DEPTH-1 in order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= tag_t'(i);
      end
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= cdb_tag;
    end
  end

  // Pointers wrap naturally. The count tells full apart from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= tag_cnt_t'(DEPTH);
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_pop_ok)  r_rd_ptr <= tag_t'(r_rd_ptr + tag_t'(1));
      if (w_push_ok) r_wr_ptr <= tag_t'(r_wr_ptr + tag_t'(1));
      if (w_push_ok && !w_pop_ok)      r_count <= tag_cnt_t'(r_count + tag_cnt_t'(1));
      else if (w_pop_ok && !w_push_ok) r_count <= tag_cnt_t'(r_count - tag_cnt_t'(1));
      if (tag_pop && !w_avail)    r_udf <= 1'b1;
      if (cdb_valid && !w_push_ok) r_ovf <= 1'b1;
    end
  end

  assign tag_out   = r_mem[r_rd_ptr];
  assign tag_avail = w_avail;
  assign tag_count = r_count;
  assign ovf_err   = r_ovf;
  assign udf_err   = r_udf;

endmodule : tag_fifo

// File: tb/tb_tag_fifo.sv
// Self-checking bench for tag_fifo. A queue-based model of the free pool
// is compared with the DUT on every falling edge. Directed sequences add
// hand-computed literal expectations.
module tb_tag_fifo;
  import riscv_sp_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             tag_pop;
  logic [TAG_W-1:0] tag_out;
  logic             tag_avail;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [TAG_W:0]   tag_count;
  logic             ovf_err;
  logic             udf_err;

  int checks   = 0;
  int failures = 0;

  tag_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .tag_pop   (tag_pop),
    .tag_out   (tag_out),
    .tag_avail (tag_avail),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .tag_count (tag_count),
    .ovf_err   (ovf_err),
    .udf_err   (udf_err)
  );

  always #5 clk = ~clk;

  // Reference model: the pool is a plain queue of tags.
  logic [TAG_W-1:0] m_q[$];
  bit               m_ovf;
  bit               m_udf;
  bit               chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      for (int i = 0; i < 64; i++) m_q.push_back(TAG_W'(i));
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      bit pop_ok, push_ok;
      pop_ok  = tag_pop && (m_q.size() > 0);
      push_ok = cdb_valid && ((m_q.size() < 64) || pop_ok);
      if (tag_pop && !pop_ok)    m_udf = 1'b1;
      if (cdb_valid && !push_ok) m_ovf = 1'b1;
      if (pop_ok)  void'(m_q.pop_front());
      if (push_ok) m_q.push_back(cdb_tag);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_count", int'(tag_count), m_q.size());
      chk("model_avail", int'(tag_avail), int'(m_q.size() != 0));
      if (m_q.size() != 0) chk("model_tag_out", int'(tag_out), int'(m_q[0]));
      chk("model_ovf", int'(ovf_err), int'(m_ovf));
      chk("model_udf", int'(udf_err), int'(m_udf));
    end
  end

  // One clock of stimulus. Inputs change #1 after the rising edge.
  task automatic cyc(input bit p, input bit v, input int t, input bit r = 1'b0);
    rst       = r;
    tag_pop   = p;
    cdb_valid = v;
    cdb_tag   = TAG_W'(t);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    tag_pop   = 1'b0;
    cdb_valid = 1'b0;
    cdb_tag   = '0;
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; tag_pop = 1'b0; cdb_valid = 1'b0; cdb_tag = '0;
    @(posedge clk); #1;
    do_reset();
    chk_en = 1'b1;

    // Reset then idle.
    repeat (3) cyc(1'b0, 1'b0, 0);
    chk("rst_tag_out", int'(tag_out), 0);
    chk("rst_avail", int'(tag_avail), 1);
    chk("rst_count", int'(tag_count), 64);
    chk("rst_ovf", int'(ovf_err), 0);
    chk("rst_udf", int'(udf_err), 0);

    // Drain the whole pool in order, then underflow.
    for (int i = 0; i < 64; i++) begin
      chk("drain_tag", int'(tag_out), i);
      cyc(1'b1, 1'b0, 0);
    end
    chk("empty_avail", int'(tag_avail), 0);
    chk("empty_count", int'(tag_count), 0);
    chk("pre_udf", int'(udf_err), 0);
    cyc(1'b1, 1'b0, 0);
    chk("udf_set", int'(udf_err), 1);
    chk("udf_count", int'(tag_count), 0);

    // Refill from empty.
    cyc(1'b0, 1'b1, 5);
    chk("push5_tag_out", int'(tag_out), 5);
    chk("push5_avail", int'(tag_avail), 1);
    cyc(1'b0, 1'b1, 9);
    chk("push9_count", int'(tag_count), 2);
    cyc(1'b1, 1'b0, 0);
    chk("pop_tag_out", int'(tag_out), 9);
    chk("pop_count", int'(tag_count), 1);

    // Pop and push together while empty: the push lands, the pop does not.
    cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 33);
    chk("empty_both_tag", int'(tag_out), 33);
    chk("empty_both_count", int'(tag_count), 1);

    // Full: simultaneous pop+push, then a push alone overflows.
    do_reset();
    cyc(1'b1, 1'b1, 3);
    chk("full_both_tag", int'(tag_out), 1);
    chk("full_both_count", int'(tag_count), 64);
    chk("full_both_ovf", int'(ovf_err), 0);
    cyc(1'b0, 1'b1, 7);
    chk("ovf_set", int'(ovf_err), 1);
    chk("ovf_count", int'(tag_count), 64);

    // Pop 62, push 62 back, then run full-rate pop+push to wrap both pointers.
    do_reset();
    repeat (62) cyc(1'b1, 1'b0, 0);
    chk("wrap_head", int'(tag_out), 62);
    chk("wrap_count2", int'(tag_count), 2);
    for (int i = 0; i < 62; i++) cyc(1'b0, 1'b1, (i * 7 + 3) % 64);
    chk("wrap_count64", int'(tag_count), 64);
    cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b0, 0);
    chk("wrap_first_pushed", int'(tag_out), 3);
    chk("wrap_count62", int'(tag_count), 62);
    for (int i = 0; i < 70; i++) cyc(1'b1, (i % 3) != 0, (i * 5 + 1) % 64);
    chk("wrap_no_ovf", int'(ovf_err), 0);

    // Reset mid-stream overrides a pop and a push in the same cycle.
    do_reset();
    cyc(1'b0, 1'b1, 1);
    chk("mid_ovf_pre", int'(ovf_err), 1);
    repeat (10) cyc(1'b1, 1'b0, 0);
    chk("mid_tag_pre", int'(tag_out), 10);
    cyc(1'b1, 1'b1, 42, 1'b1);
    chk("mid_count", int'(tag_count), 64);
    chk("mid_tag_out", int'(tag_out), 0);
    chk("mid_ovf", int'(ovf_err), 0);
    chk("mid_udf", int'(udf_err), 0);

    // Randomized traffic in phases with different pop/push biases.
    for (int ph = 0; ph < 8; ph++) begin
      int pp, vp;
      pp = int'($urandom_range(10, 90));
      vp = int'($urandom_range(10, 90));
      for (int i = 0; i < 400; i++) begin
        cyc(int'($urandom_range(0, 99)) < pp,
            int'($urandom_range(0, 99)) < vp,
            int'($urandom_range(0, 63)),
            $urandom_range(0, 299) == 0);
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_tag_fifo
